// File: rtl/rf_check_monitor.sv
// rf_check_monitor
// End-of-run register-file checker for the RV32I pipeline core. It snoops the
// writeback port during RUN and keeps shadow copies of NUM_CHK programmed
// architectural registers. RUN ends on TIMEOUT, or on core halt when the
// optional feature is built in. CHECK then compares each shadow against its
// programmed expected value, one slot per cycle, and DONE holds the verdict.
//
// Optional feature: define RF_CHK_HALT_EN so that halt ends RUN early.
// Without the macro the halt port exists but is ignored.
//
// Ports:
//   clk, rst_n       core clock, asynchronous active-low reset
//   cfg_we/idx/reg/exp  slot programming, accepted only in IDLE
//   start            pulse: IDLE or DONE -> RUN
//   wb_we/rd/data    writeback port from the WB stage, snooped in RUN
//   halt             core retired ecall/ebreak
//   busy             high in RUN and CHECK
//   done             high in DONE
//   pass             valid in DONE; 1 iff fail_cnt == 0
//   fail_cnt         number of mismatching slots
//   first_fail_idx   lowest failing slot
//   first_fail_got   shadow value of that slot
//   cycles           RUN cycles elapsed, frozen after RUN
module rf_check_monitor #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_CHK = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 120,
  localparam int IDX_W  = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1,
  localparam int FCNT_W = $clog2(NUM_CHK + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [REG_AW-1:0] cfg_reg,
  input  logic [XLEN-1:0]   cfg_exp,
  input  logic              start,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              halt,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [FCNT_W-1:0] fail_cnt,
  output logic [IDX_W-1:0]  first_fail_idx,
  output logic [XLEN-1:0]   first_fail_got,
  output logic [CNT_W-1:0]  cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state;

  logic [REG_AW-1:0] slot_reg [NUM_CHK];
  logic [XLEN-1:0]   slot_exp [NUM_CHK];
  logic [XLEN-1:0]   shadow   [NUM_CHK];
  logic [IDX_W-1:0]  scan_idx;

  logic mismatch;
  logic scan_last;
  logic run_exit;
  logic cfg_hit;
  logic wb_capture;

  always_comb begin
    mismatch   = shadow[scan_idx] != slot_exp[scan_idx];
    scan_last  = scan_idx == IDX_W'(NUM_CHK - 1);
    cfg_hit    = cfg_we && (32'(cfg_idx) < 32'(NUM_CHK));
    wb_capture = wb_we && (wb_rd != '0);
`ifdef RF_CHK_HALT_EN
    // Halt and timeout lead to the same transition, so no priority logic is needed.
    run_exit   = halt || (cycles == CNT_W'(TIMEOUT - 1));
`else
    run_exit   = cycles == CNT_W'(TIMEOUT - 1);
`endif
  end

`ifndef RF_CHK_HALT_EN
  logic halt_unused;
  assign halt_unused = halt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      first_fail_got <= '0;
      cycles         <= '0;
      scan_idx       <= '0;
      for (int unsigned i = 0; i < NUM_CHK; i++) begin
        slot_reg[i] <= '0;
        slot_exp[i] <= '0;
        shadow[i]   <= '0;
      end
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (state == S_IDLE && cfg_hit) begin
            slot_reg[cfg_idx] <= cfg_reg;
            slot_exp[cfg_idx] <= cfg_exp;
          end
          if (start) begin
            state          <= S_RUN;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_got <= '0;
            cycles         <= '0;
            scan_idx       <= '0;
            for (int unsigned i = 0; i < NUM_CHK; i++) begin
              shadow[i] <= '0;
            end
          end
        end

        S_RUN: begin
          if (cycles != '1) begin
            cycles <= cycles + CNT_W'(1);
          end
          // Aliased slots all capture the same writeback.
          for (int unsigned i = 0; i < NUM_CHK; i++) begin
            if (wb_capture && slot_reg[i] == wb_rd) begin
              shadow[i] <= wb_data;
            end
          end
          if (run_exit) begin
            state    <= S_CHECK;
            scan_idx <= '0;
          end
        end

        S_CHECK: begin
          if (mismatch) begin
            fail_cnt <= fail_cnt + FCNT_W'(1);
            if (fail_cnt == '0) begin
              first_fail_idx <= scan_idx;
              first_fail_got <= shadow[scan_idx];
            end
          end
          if (scan_last) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_cnt == '0) && !mismatch;
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_check_monitor.sv
// Directed bench for rf_check_monitor with NUM_CHK=5, TIMEOUT=120.
// Expected values are hand-computed constants per scenario.
module tb_rf_check_monitor;

  localparam int NC = 5;
  localparam int TO = 120;

`ifdef RF_CHK_HALT_EN
  localparam int HALT_CYC   = 30;
  localparam int HALT_EDGES = 35;
`else
  localparam int HALT_CYC   = 120;
  localparam int HALT_EDGES = 125;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_idx = '0;
  logic [4:0]  cfg_reg = '0;
  logic [31:0] cfg_exp = '0;
  logic        start = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        halt = 1'b0;
  logic        busy;
  logic        done;
  logic        pass;
  logic [2:0]  fail_cnt;
  logic [2:0]  first_fail_idx;
  logic [31:0] first_fail_got;
  logic [15:0] cycles;

  rf_check_monitor #(
    .XLEN    (32),
    .REG_AW  (5),
    .NUM_CHK (NC),
    .CNT_W   (16),
    .TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_we         (cfg_we),
    .cfg_idx        (cfg_idx),
    .cfg_reg        (cfg_reg),
    .cfg_exp        (cfg_exp),
    .start          (start),
    .wb_we          (wb_we),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .halt           (halt),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail_cnt       (fail_cnt),
    .first_fail_idx (first_fail_idx),
    .first_fail_got (first_fail_got),
    .cycles         (cycles)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Writeback events for the next run, keyed by RUN cycle number.
  int          ev_k   [$];
  logic [4:0]  ev_rd  [$];
  logic [31:0] ev_dat [$];
  int          halt_k = -1;
  int          cfg_k  = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic program_slot(input int idx, input int rg, input logic [31:0] ex);
    @(negedge clk);
    cfg_we  = 1'b1;
    cfg_idx = idx[2:0];
    cfg_reg = rg[4:0];
    cfg_exp = ex;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic add_wb(input int k, input int rd, input logic [31:0] d);
    ev_k.push_back(k);
    ev_rd.push_back(rd[4:0]);
    ev_dat.push_back(d);
  endtask

  task automatic clear_events();
    ev_k.delete();
    ev_rd.delete();
    ev_dat.delete();
    halt_k = -1;
    cfg_k  = -1;
  endtask

  // Pulse start (optionally with a same-cycle config write), then drive the
  // event table until done rises or the cycle budget runs out.
  task automatic run(input string t, input bit with_cfg, input int ci, input int ri,
                     input logic [31:0] ce, output int edges);
    @(negedge clk);
    start = 1'b1;
    if (with_cfg) begin
      cfg_we  = 1'b1;
      cfg_idx = ci[2:0];
      cfg_reg = ri[4:0];
      cfg_exp = ce;
    end
    @(negedge clk);
    start  = 1'b0;
    cfg_we = 1'b0;
    check({t, ".busy_run"}, {31'd0, busy}, 32'd1);
    check({t, ".done_run"}, {31'd0, done}, 32'd0);
    edges = 0;
    while (!done && edges < 1000) begin
      for (int j = 0; j < ev_k.size(); j++) begin
        if (ev_k[j] == edges) begin
          wb_we   = 1'b1;
          wb_rd   = ev_rd[j];
          wb_data = ev_dat[j];
        end
      end
      halt = (edges == halt_k);
      if (edges == cfg_k) begin
        cfg_we  = 1'b1;
        cfg_idx = 3'd1;
        cfg_reg = 5'd9;
        cfg_exp = 32'h55;
      end
      @(negedge clk);
      edges++;
      wb_we  = 1'b0;
      halt   = 1'b0;
      cfg_we = 1'b0;
    end
    check({t, ".done_seen"}, {31'd0, done}, 32'd1);
  endtask

  task automatic check_res(input string t, input int edges, input int exp_edges,
                           input logic [31:0] e_pass, input logic [31:0] e_fail,
                           input logic [31:0] e_idx, input logic [31:0] e_got,
                           input logic [31:0] e_cyc);
    check({t, ".latency"}, 32'(edges), 32'(exp_edges));
    check({t, ".busy"}, {31'd0, busy}, 32'd0);
    check({t, ".pass"}, {31'd0, pass}, e_pass);
    check({t, ".fail_cnt"}, {29'd0, fail_cnt}, e_fail);
    check({t, ".first_idx"}, {29'd0, first_fail_idx}, e_idx);
    check({t, ".first_got"}, first_fail_got, e_got);
    check({t, ".cycles"}, {16'd0, cycles}, e_cyc);
  endtask

  task automatic program_base();
    program_slot(0, 8, 32'h100);
    program_slot(1, 9, 32'h2A);
    program_slot(2, 28, 32'h12A);
    program_slot(3, 29, 32'h0);
    program_slot(4, 5, 32'h100);
  endtask

  task automatic events_match();
    clear_events();
    add_wb(5, 8, 32'h100);
    add_wb(20, 9, 32'h2A);
    add_wb(40, 28, 32'h12A);
    add_wb(50, 7, 32'h5);
    add_wb(119, 5, 32'h100);   // last RUN cycle: must still be captured
  endtask

  int e;

  initial begin
    #2;
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.done", {31'd0, done}, 32'd0);
    check("reset.pass", {31'd0, pass}, 32'd0);
    check("reset.fail_cnt", {29'd0, fail_cnt}, 32'd0);
    check("reset.cycles", {16'd0, cycles}, 32'd0);
    check("reset.first_got", first_fail_got, 32'd0);
    rst_n = 1'b1;

    // 1: matching writebacks
    program_base();
    events_match();
    run("t1", 1'b0, 0, 0, 32'h0, e);
    check_res("t1", e, 125, 1, 0, 0, 32'h0, 120);

    // 2: from DONE, same config, x9/x28/x5 end wrong
    clear_events();
    add_wb(5, 8, 32'h100);
    add_wb(20, 9, 32'h2A);
    add_wb(30, 9, 32'h29);
    add_wb(40, 28, 32'h129);
    add_wb(119, 5, 32'hFF);
    run("t2", 1'b0, 0, 0, 32'h0, e);
    check_res("t2", e, 125, 0, 3, 1, 32'h29, 120);

    // 5: halt with an x8 write in that cycle (RUN cycle 30)
    clear_events();
    add_wb(29, 8, 32'h100);
    halt_k = 29;
    run("t5", 1'b0, 0, 0, 32'h0, e);
    check_res("t5", e, HALT_EDGES, 0, 3, 1, 32'h0, 32'(HALT_CYC));

    // Config writes in DONE are ignored
    program_slot(0, 8, 32'hBAD);
    events_match();
    run("done_cfg", 1'b0, 0, 0, 32'h0, e);
    check_res("done_cfg", e, 125, 1, 0, 0, 32'h0, 120);

    // 3: slot mapped to x0; slot 4 programmed in the same cycle as start
    do_reset();
    program_slot(0, 0, 32'h0);
    program_slot(1, 1, 32'h0);
    program_slot(2, 2, 32'h0);
    program_slot(3, 3, 32'h0);
    clear_events();
    add_wb(3, 0, 32'hDEAD);
    add_wb(10, 4, 32'h44);
    run("t3", 1'b1, 4, 4, 32'h44, e);
    check_res("t3", e, 125, 1, 0, 0, 32'h0, 120);

    // 4: two slots alias x9; config write during RUN must be ignored
    do_reset();
    program_slot(0, 1, 32'h0);
    program_slot(1, 9, 32'h2A);
    program_slot(2, 9, 32'h2A);
    program_slot(3, 3, 32'h0);
    program_slot(4, 4, 32'h0);
    clear_events();
    add_wb(10, 9, 32'h11);
    add_wb(11, 9, 32'h2A);
    cfg_k = 5;
    run("t4", 1'b0, 0, 0, 32'h0, e);
    check_res("t4", e, 125, 1, 0, 0, 32'h0, 120);

    // 6: reset mid-CHECK, then restart on the cleared config
    do_reset();
    program_base();
    clear_events();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (122) @(negedge clk);
    check("t6.busy_check", {31'd0, busy}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6.rst_busy", {31'd0, busy}, 32'd0);
    check("t6.rst_done", {31'd0, done}, 32'd0);
    check("t6.rst_pass", {31'd0, pass}, 32'd0);
    check("t6.rst_fail", {29'd0, fail_cnt}, 32'd0);
    check("t6.rst_cycles", {16'd0, cycles}, 32'd0);
    check("t6.rst_idx", {29'd0, first_fail_idx}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("t6", 1'b0, 0, 0, 32'h0, e);
    check_res("t6", e, 125, 1, 0, 0, 32'h0, 120);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
